lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store control unit between the MEM pipeline stage and the byte-lane data RAM. It accepts one load or store per transaction from the EX/MEM latch and converts RISC-V funct3 plus address into a RAM request (valid/write/byte enables/lane-aligned data). It holds the request while the RAM reports busy, stalls the pipeline, and returns a sign- or zero-extended load result or a fault code.

## Interface
- MEM_BYTES, 1024: RAM size in bytes; accesses ending at or above this fault.
- TIMEOUT, 15: max cycles in WAIT with mem_busy high before a timeout fault.
- ALLOW_MISALIGNED, 1: 1 = non-naturally-aligned halfword/word allowed; 0 = fault.

- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- ex_valid  in  1  request present from EX/MEM latch
- ex_load  in  1  request is a load
- ex_store  in  1  request is a store
- ex_funct3  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- ex_addr  in  32  byte address
- ex_wdata  in  32  store source (rs2)
- stall_o  out  1  pipeline must hold
- done_o  out  1  one-cycle completion pulse
- load_data_o  out  32  extended load result
- fault_o  out  1  completion carries a fault (valid with done_o)
- fault_cause_o  out  3  0 none, 1 misaligned, 2 out of range, 3 illegal, 4 timeout
- mem_valid  out  1  RAM request
- mem_write  out  1  1 store, 0 load
- mem_byte  out  4  lane enables; lane i = byte at addr+i
- mem_addr  out  32  request address
- mem_store_data  out  32  lane-aligned store data, byte at addr in [7:0]
- mem_data_i  in  32  RAM read data; only enabled lanes meaningful
- mem_busy  in  1  RAM still working

## Operation
- States IDLE, REQ, WAIT, DONE.
- IDLE: accept when ex_valid & (ex_load | ex_store); latch funct3, addr, wdata, direction; go REQ. If checks fail, go DONE with fault, no mem access.
- Checks, in priority order:
  - both load and store, or an undefined funct3 (load 011/110/111, store 011-111) -> cause 3.
  - misaligned (half addr[0]=1, word addr[1:0]!=0) with ALLOW_MISALIGNED=0 -> cause 1.
  - addr+size-1 >= MEM_BYTES, computed 33-bit so no wrap -> cause 2.
- Size/enables: byte 0001, half 0011, word 1111. mem_store_data = latched wdata unshifted.
- REQ: mem_valid=1; clear wait counter; go WAIT.
- WAIT: mem_valid held 1, all mem_* outputs stable.
  - mem_busy=0 at an edge: capture mem_data_i, go DONE.
  - counter reaches TIMEOUT with busy high: go DONE with cause 4; load_data_o unchanged.
- Load extension, done on captured data: disabled lanes forced 0.
  - LB: sign-extend [7:0]. LBU: zero-extend [7:0].
  - LH: sign-extend [15:0]. LHU: zero-extend [15:0].
  - LW: pass [31:0].
- DONE: done_o=1, stall_o=0, mem_valid=0; go IDLE. load_data_o updates only on successful load; it holds otherwise.
- Stores produce done_o with load_data_o unchanged.

## Timing
- Reset values, all outputs: state IDLE, mem_valid 0, mem_write 0, mem_byte 0, mem_addr 0, mem_store_data 0, load_data_o 0, done_o 0, fault_o 0, fault_cause_o 0, stall_o 0.
- stall_o is combinational: high in IDLE when a request is presented, and in REQ and WAIT. It is low in DONE and when idle.
- Latency with mem_busy low throughout: accept edge -> REQ -> WAIT -> DONE. done_o is high in the 3rd cycle after the accept cycle. Each busy-high WAIT cycle adds 1.
- Fault at accept: done_o in the next cycle; mem_valid never asserted.
- Back-to-back: a new request can be accepted in the cycle after DONE (in IDLE); no accept in DONE.
- rst mid-transaction: IDLE at next edge, mem_valid drops. A store may be partially written; no done_o is produced.
- Pipeline must hold ex_* stable while stall_o=1; they are sampled only at accept.

## Structure
- Package lsu_pkg:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - state enum.
  - fault cause codes.
  - size-to-byte-enable function.
- Sub-module lsu_load_align: combinational lane mask plus sign/zero extension (captured data, funct3 -> 32-bit result).
- Top holds the FSM, request latch, checks and wait counter.

## Test plan
- LW addr 0x10, RAM returns 0xDEADBEEF, busy low -> mem_byte 1111; done_o 3 cycles after accept; load_data_o 0xDEADBEEF, fault_o 0.
- LB addr 0x21, data 0x00000080 -> mem_byte 0001, mem_addr 0x21, load_data_o 0xFFFFFF80. Same with LBU -> 0x00000080. LH data 0x00008001 -> 0xFFFF8001.
- SH addr 0x40, wdata 0x1234ABCD, busy high 4 cycles -> mem_write 1, mem_byte 0011, mem_store_data 0x1234ABCD, signals stable across WAIT; done_o 7 cycles after accept.
- LW addr 0x3FE with MEM_BYTES=1024 -> fault cause 2, no mem_valid. LW addr 0x2 with ALLOW_MISALIGNED=0 -> cause 1. Load funct3 011 -> cause 3.
- mem_busy stuck high -> done_o with cause 4 after TIMEOUT WAIT cycles; load_data_o retains previous value.
- rst asserted in WAIT -> next cycle IDLE, mem_valid 0, stall_o 0, no done_o; following LW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store control unit: funct3 encodings,
// FSM states, fault codes and access-size decoding.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_e;

  typedef enum logic [2:0] {
    C_NONE     = 3'd0,
    C_MISALIGN = 3'd1,
    C_RANGE    = 3'd2,
    C_ILLEGAL  = 3'd3,
    C_TIMEOUT  = 3'd4
  } fault_cause_e;

  // funct3[1:0] encodes the access size for both loads and stores.
  function automatic logic [3:0] size_to_be(input logic [1:0] size);
    case (size)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
    case (size)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic load_f3_legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic store_f3_legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load result formatting: masks lanes the access did not enable, then applies
// sign or zero extension selected by funct3.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [31:0] data_i,
  output logic [31:0] result_o
);

  logic [3:0]  be;
  logic [31:0] masked;

  always_comb begin
    be     = size_to_be(funct3_i[1:0]);
    masked = data_i & {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    case (funct3_i)
      F3_B:    result_o = {{24{masked[7]}}, masked[7:0]};
      F3_BU:   result_o = {24'b0, masked[7:0]};
      F3_H:    result_o = {{16{masked[15]}}, masked[15:0]};
      F3_HU:   result_o = {16'b0, masked[15:0]};
      default: result_o = masked;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control unit: accepts one MEM-stage access, checks it, drives a
// held RAM request until the RAM finishes or times out, and reports completion.
//
// state | meaning
// IDLE  | waiting for a load/store from EX/MEM
// REQ   | first request cycle, wait timer loaded
// WAIT  | request held until mem_busy drops or the timer expires
// DONE  | one-cycle completion pulse, result or fault valid
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES        = 1024,
  parameter int unsigned TIMEOUT          = 15,
  parameter bit          ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_load,
  input  logic        ex_store,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] load_data_o,
  output logic        fault_o,
  output logic [2:0]  fault_cause_o,
  output logic        mem_valid,
  output logic        mem_write,
  output logic [3:0]  mem_byte,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_store_data,
  input  logic [31:0] mem_data_i,
  input  logic        mem_busy
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  lsu_state_e   state_q, state_d;
  logic [2:0]   f3_q;
  logic [31:0]  addr_q;
  logic [31:0]  wdata_q;
  logic         write_q;
  logic [3:0]   be_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic         fault_q;
  fault_cause_e cause_q;
  logic [31:0]  load_data_q;

  logic         accept;
  logic         illegal;
  logic         misaligned;
  logic [32:0]  end_addr;
  fault_cause_e chk_cause;
  logic [31:0]  aligned;

  assign accept = (state_q == S_IDLE) && ex_valid && (ex_load || ex_store);

  // Range check uses 33 bits so an access near 0xFFFFFFFF cannot wrap to a low address.
  always_comb begin
    illegal    = (ex_load && ex_store) ||
                 (ex_load && !load_f3_legal(ex_funct3)) ||
                 (ex_store && !store_f3_legal(ex_funct3));
    misaligned = ((ex_funct3[1:0] == 2'b01) && ex_addr[0]) ||
                 ((ex_funct3[1:0] == 2'b10) && (ex_addr[1:0] != 2'b00));
    end_addr   = {1'b0, ex_addr} + {30'b0, size_to_bytes(ex_funct3[1:0])} - 33'd1;
    chk_cause  = C_NONE;
    if (illegal) begin
      chk_cause = C_ILLEGAL;
    end else if (!ALLOW_MISALIGNED && misaligned) begin
      chk_cause = C_MISALIGN;
    end else if (end_addr >= 33'(MEM_BYTES)) begin
      chk_cause = C_RANGE;
    end
  end

  lsu_load_align u_align (
    .funct3_i (f3_q),
    .data_i   (mem_data_i),
    .result_o (aligned)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = (chk_cause == C_NONE) ? S_REQ : S_DONE;
        end
      end
      S_REQ:  state_d = S_WAIT;
      S_WAIT: begin
        if (!mem_busy || (cnt_q == '0)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_valid     = (state_q == S_REQ) || (state_q == S_WAIT);
    stall_o       = accept || mem_valid;
    done_o        = (state_q == S_DONE);
    fault_o       = done_o && fault_q;
    fault_cause_o = done_o ? cause_q : C_NONE;
  end

  // Down-counter: loaded in REQ, terminal count 0 ends the WAIT window.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_REQ) begin
      cnt_d = CW'(TIMEOUT - 1);
    end else if ((state_q == S_WAIT) && mem_busy && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f3_q        <= 3'b0;
      addr_q      <= 32'b0;
      wdata_q     <= 32'b0;
      write_q     <= 1'b0;
      be_q        <= 4'b0;
      cnt_q       <= '0;
      fault_q     <= 1'b0;
      cause_q     <= C_NONE;
      load_data_q <= 32'b0;
    end else begin
      cnt_q <= cnt_d;
      if (accept) begin
        fault_q <= (chk_cause != C_NONE);
        cause_q <= chk_cause;
        // A rejected access leaves the RAM-facing fields at the last real request.
        if (chk_cause == C_NONE) begin
          f3_q    <= ex_funct3;
          addr_q  <= ex_addr;
          wdata_q <= ex_wdata;
          write_q <= ex_store;
          be_q    <= size_to_be(ex_funct3[1:0]);
        end
      end
      if (state_q == S_WAIT) begin
        if (!mem_busy) begin
          if (!write_q) begin
            load_data_q <= aligned;
          end
        end else if (cnt_q == '0) begin
          fault_q <= 1'b1;
          cause_q <= C_TIMEOUT;
        end
      end
    end
  end

  assign load_data_o    = load_data_q;
  assign mem_write      = write_q;
  assign mem_byte       = be_q;
  assign mem_addr       = addr_q;
  assign mem_store_data = wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: a table of single transactions with hand-computed
// results, then back-to-back and mid-transaction reset sequences.
module tb_lsu_ctrl;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ex_load;
  logic        ex_store;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic        stall_o;
  logic        done_o;
  logic [31:0] load_data_o;
  logic        fault_o;
  logic [2:0]  fault_cause_o;
  logic        mem_valid;
  logic        mem_write;
  logic [3:0]  mem_byte;
  logic [31:0] mem_addr;
  logic [31:0] mem_store_data;
  logic [31:0] mem_data_i;
  logic        mem_busy;

  int errors = 0;
  int checks = 0;

  lsu_ctrl #(
    .MEM_BYTES        (1024),
    .TIMEOUT          (15),
    .ALLOW_MISALIGNED (1'b0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid       (ex_valid),
    .ex_load        (ex_load),
    .ex_store       (ex_store),
    .ex_funct3      (ex_funct3),
    .ex_addr        (ex_addr),
    .ex_wdata       (ex_wdata),
    .stall_o        (stall_o),
    .done_o         (done_o),
    .load_data_o    (load_data_o),
    .fault_o        (fault_o),
    .fault_cause_o  (fault_cause_o),
    .mem_valid      (mem_valid),
    .mem_write      (mem_write),
    .mem_byte       (mem_byte),
    .mem_addr       (mem_addr),
    .mem_store_data (mem_store_data),
    .mem_data_i     (mem_data_i),
    .mem_busy       (mem_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          busy_n;
    logic [3:0]  exp_be;
    logic [2:0]  exp_cause;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input string n, input logic ld, input logic st,
                              input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input int busy_n, input logic [3:0] be,
                              input logic [2:0] cause, input logic [31:0] data,
                              input int lat);
    vec_t v;
    v.name = n; v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr;
    v.wdata = wdata; v.rdata = rdata; v.busy_n = busy_n; v.exp_be = be;
    v.exp_cause = cause; v.exp_data = data; v.exp_lat = lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int          done_c;
    int          mv_cnt;
    int          stall_bad;
    logic        f_s;
    logic [2:0]  c_s;
    logic [31:0] d_s;
    logic        exp_mv;
    done_c = -1; mv_cnt = 0; stall_bad = 0;
    f_s = 1'b0; c_s = 3'b0; d_s = 32'b0;
    exp_mv = (v.exp_cause == 3'd0) || (v.exp_cause == 3'd4);
    @(negedge clk);
    ex_valid = 1'b1; ex_load = v.ld; ex_store = v.st; ex_funct3 = v.f3;
    ex_addr = v.addr; ex_wdata = v.wdata; mem_data_i = v.rdata; mem_busy = 1'b1;
    #1;
    if (!stall_o) stall_bad++;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done_o) begin
        done_c = c;
        f_s = fault_o; c_s = fault_cause_o; d_s = load_data_o;
        check($sformatf("%s_done_quiet", v.name), {62'b0, stall_o, mem_valid}, 64'd0);
        ex_valid = 1'b0;
        mem_busy = 1'b0;
        break;
      end
      if (!stall_o) stall_bad++;
      if (mem_valid) begin
        mv_cnt++;
        check($sformatf("%s_req", v.name), {27'b0, mem_write, mem_byte, mem_addr},
              {27'b0, v.st, v.exp_be, v.addr});
        check($sformatf("%s_sdata", v.name), {32'b0, mem_store_data}, {32'b0, v.wdata});
        mem_busy = (mv_cnt >= 2) ? ((mv_cnt - 2) < v.busy_n) : 1'b1;
      end
    end
    check($sformatf("%s_latency", v.name), 64'(done_c), 64'(v.exp_lat));
    check($sformatf("%s_fault", v.name), {63'b0, f_s}, {63'b0, v.exp_cause != 3'd0});
    check($sformatf("%s_cause", v.name), {61'b0, c_s}, {61'b0, v.exp_cause});
    check($sformatf("%s_ldata", v.name), {32'b0, d_s}, {32'b0, v.exp_data});
    check($sformatf("%s_mv_cycles", v.name), 64'(mv_cnt), exp_mv ? 64'(v.exp_lat - 1) : 64'd0);
    check($sformatf("%s_stall", v.name), 64'(stall_bad), 64'd0);
  endtask

  initial begin
    logic [9:0] dmask;
    logic       stall3;
    int         ndone;

    rst = 1'b1; ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
    ex_funct3 = 3'b0; ex_addr = 32'b0; ex_wdata = 32'b0;
    mem_data_i = 32'b0; mem_busy = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ctrl", {52'b0, mem_valid, mem_write, mem_byte, done_o, fault_o, fault_cause_o, stall_o},
          64'd0);
    check("reset_addr_sdata", {mem_addr, mem_store_data}, 64'd0);
    check("reset_ldata", {32'b0, load_data_o}, 64'd0);
    rst = 1'b0;

    vq.push_back(mk("lw_10",    1, 0, 3'b010, 32'h10,  32'h0, 32'hDEADBEEF, 0, 4'hF, 3'd0, 32'hDEADBEEF, 3));
    vq.push_back(mk("lb_21",    1, 0, 3'b000, 32'h21,  32'h0, 32'h00000080, 0, 4'h1, 3'd0, 32'hFFFFFF80, 3));
    vq.push_back(mk("lbu_21",   1, 0, 3'b100, 32'h21,  32'h0, 32'h00000080, 0, 4'h1, 3'd0, 32'h00000080, 3));
    vq.push_back(mk("lh_20",    1, 0, 3'b001, 32'h20,  32'h0, 32'h00008001, 0, 4'h3, 3'd0, 32'hFFFF8001, 3));
    vq.push_back(mk("lhu_3fe",  1, 0, 3'b101, 32'h3FE, 32'h0, 32'hFFFF8001, 1, 4'h3, 3'd0, 32'h00008001, 4));
    vq.push_back(mk("lb_3ff",   1, 0, 3'b000, 32'h3FF, 32'h0, 32'hABCDEF7F, 0, 4'h1, 3'd0, 32'h0000007F, 3));
    vq.push_back(mk("sh_40",    0, 1, 3'b001, 32'h40,  32'h1234ABCD, 32'hFFFFFFFF, 4, 4'h3, 3'd0, 32'h7F, 7));
    vq.push_back(mk("sw_3fc",   0, 1, 3'b010, 32'h3FC, 32'hCAFEF00D, 32'h0, 1, 4'hF, 3'd0, 32'h7F, 4));
    vq.push_back(mk("lw_400",   1, 0, 3'b010, 32'h400, 32'h0, 32'h0, 0, 4'h0, 3'd2, 32'h7F, 1));
    vq.push_back(mk("lw_top",   1, 0, 3'b010, 32'hFFFFFFFC, 32'h0, 32'h0, 0, 4'h0, 3'd2, 32'h7F, 1));
    vq.push_back(mk("sb_400",   0, 1, 3'b000, 32'h400, 32'h55, 32'h0, 0, 4'h0, 3'd2, 32'h7F, 1));
    vq.push_back(mk("lw_2",     1, 0, 3'b010, 32'h2,   32'h0, 32'h0, 0, 4'h0, 3'd1, 32'h7F, 1));
    vq.push_back(mk("lh_21",    1, 0, 3'b001, 32'h21,  32'h0, 32'h0, 0, 4'h0, 3'd1, 32'h7F, 1));
    vq.push_back(mk("lh_401",   1, 0, 3'b001, 32'h401, 32'h0, 32'h0, 0, 4'h0, 3'd1, 32'h7F, 1));
    vq.push_back(mk("ld_f3_011",1, 0, 3'b011, 32'h8,   32'h0, 32'h0, 0, 4'h0, 3'd3, 32'h7F, 1));
    vq.push_back(mk("ld_f3_111",1, 0, 3'b111, 32'h401, 32'h0, 32'h0, 0, 4'h0, 3'd3, 32'h7F, 1));
    vq.push_back(mk("st_f3_100",0, 1, 3'b100, 32'h8,   32'h0, 32'h0, 0, 4'h0, 3'd3, 32'h7F, 1));
    vq.push_back(mk("ld_and_st",1, 1, 3'b010, 32'h8,   32'h0, 32'h0, 0, 4'h0, 3'd3, 32'h7F, 1));
    vq.push_back(mk("lw_tmo",   1, 0, 3'b010, 32'h80,  32'h0, 32'h11111111, 100, 4'hF, 3'd4, 32'h7F, 17));
    vq.push_back(mk("lw_84",    1, 0, 3'b010, 32'h84,  32'h0, 32'h76543210, 2, 4'hF, 3'd0, 32'h76543210, 5));

    foreach (vq[i]) run_vec(vq[i]);

    // Request held through DONE: the second accept must wait for IDLE.
    @(negedge clk);
    ex_valid = 1'b1; ex_load = 1'b1; ex_store = 1'b0; ex_funct3 = 3'b000;
    ex_addr = 32'h30; ex_wdata = 32'h0; mem_data_i = 32'h000000FF; mem_busy = 1'b0;
    dmask = '0; stall3 = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      dmask[c] = done_o;
      if (c == 3) stall3 = stall_o;
      if (c == 5) ex_valid = 1'b0;
    end
    check("b2b_done_pattern", {54'b0, dmask}, 64'h88);
    check("b2b_stall_in_done", {63'b0, stall3}, 64'd0);
    check("b2b_ldata", {32'b0, load_data_o}, 64'hFFFFFFFF);

    // Synchronous reset while the RAM is still busy.
    @(negedge clk);
    ex_valid = 1'b1; ex_load = 1'b1; ex_store = 1'b0; ex_funct3 = 3'b010;
    ex_addr = 32'h88; mem_busy = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_pre_mv", {63'b0, mem_valid}, 64'd1);
    rst = 1'b1; ex_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0; mem_busy = 1'b0;
    check("rst_quiet", {61'b0, mem_valid, stall_o, done_o}, 64'd0);
    check("rst_addr", {32'b0, mem_addr}, 64'd0);
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_o) ndone++;
    end
    check("rst_no_done", 64'(ndone), 64'd0);
    run_vec(mk("lw_after_rst", 1, 0, 3'b010, 32'h90, 32'h0, 32'h0BADF00D, 0, 4'hF, 3'd0, 32'h0BADF00D, 3));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
